// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register address width, the scoreboard entry
// record and the x0 constant.
package cpu_pkg;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } entry_t;

  // x0 is hardwired to zero, so writes to it never produce a value.
  function automatic logic is_producer(entry_t e);
    return e.v & e.rw & (e.rd != REG_ZERO);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and pipeline-control response bundle of the hazard scoreboard.
// The pipeline (master) drives the ID fields and flush/busy; the scoreboard
// (slave) answers combinationally in the same cycle, with no handshake.
interface hazard_scoreboard_if #(parameter int CNT_W = 32);
  import cpu_pkg::*;

  logic [REG_AW-1:0] rs1_i;
  logic [REG_AW-1:0] rs2_i;
  logic              rs1_used_i;
  logic              rs2_used_i;
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              flush_i;
  logic              dmem_busy_i;
  logic              stall_o;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              idex_bubble_o;
  logic              bypass_a_o;
  logic              bypass_b_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  entry_t            ex_entry_o;
  entry_t            mem_entry_o;
  entry_t            wb_entry_o;

  modport master (
    output rs1_i, rs2_i, rs1_used_i, rs2_used_i, id_valid_i, id_rd_i,
           id_regwrite_i, id_memread_i, flush_i, dmem_busy_i,
    input  stall_o, pc_write_o, ifid_write_o, idex_bubble_o, bypass_a_o,
           bypass_b_o, stall_cnt_o, ex_entry_o, mem_entry_o, wb_entry_o
  );

  modport slave (
    input  rs1_i, rs2_i, rs1_used_i, rs2_used_i, id_valid_i, id_rd_i,
           id_regwrite_i, id_memread_i, flush_i, dmem_busy_i,
    output stall_o, pc_write_o, ifid_write_o, idex_bubble_o, bypass_a_o,
           bypass_b_o, stall_cnt_o, ex_entry_o, mem_entry_o, wb_entry_o
  );
endinterface

// File: rtl/scoreboard_stage.sv
// One scoreboard entry register: it holds during a freeze, loads an empty
// entry on a bubble, and otherwise captures the entry arriving from upstream.
module scoreboard_stage
  import cpu_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   hold,
  input  logic   bubble,
  input  entry_t d,
  output entry_t q
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (!hold) begin
      q <= bubble ? entry_t'('0) : d;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination writes through EX/MEM/WB, detects load-use hazards in ID,
// and drives stall/bubble controls, WB write-through bypass selects and a stall counter.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hazard_scoreboard_if.slave   bus
);
  entry_t            ex_q;
  entry_t            mem_q;
  entry_t            wb_q;
  entry_t            id_entry;
  logic              hz;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  assign id_entry = '{v:  bus.id_valid_i, rd: bus.id_rd_i,
                      rw: bus.id_regwrite_i, mr: bus.id_memread_i};

  // Only a load sitting in EX needs a stall; a load in MEM reaches EX via forwarding.
  assign hz = bus.id_valid_i & ex_q.v & ex_q.rw & ex_q.mr & (ex_q.rd != REG_ZERO) &
              ((bus.rs1_used_i & (bus.rs1_i == ex_q.rd)) |
               (bus.rs2_used_i & (bus.rs2_i == ex_q.rd)));

  // A flush discards the dependent instruction, and a freeze defers the decision.
  assign stall = hz & ~bus.flush_i & ~bus.dmem_busy_i;

  scoreboard_stage u_ex (
    .clk_i (clk_i), .rst_i (rst_i), .hold (bus.dmem_busy_i),
    .bubble(stall | bus.flush_i), .d (id_entry), .q (ex_q)
  );

  scoreboard_stage u_mem (
    .clk_i (clk_i), .rst_i (rst_i), .hold (bus.dmem_busy_i),
    .bubble(1'b0), .d (ex_q), .q (mem_q)
  );

  scoreboard_stage u_wb (
    .clk_i (clk_i), .rst_i (rst_i), .hold (bus.dmem_busy_i),
    .bubble(1'b0), .d (mem_q), .q (wb_q)
  );

  // Saturating count; stall is already low whenever the pipeline is frozen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_o       = stall;
  assign bus.pc_write_o    = ~stall & ~bus.dmem_busy_i;
  assign bus.ifid_write_o  = ~stall & ~bus.dmem_busy_i;
  assign bus.idex_bubble_o = (stall | bus.flush_i) & ~bus.dmem_busy_i;
  assign bus.bypass_a_o    = bus.rs1_used_i & is_producer(wb_q) & (wb_q.rd == bus.rs1_i);
  assign bus.bypass_b_o    = bus.rs2_used_i & is_producer(wb_q) & (wb_q.rd == bus.rs2_i);
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.ex_entry_o    = ex_q;
  assign bus.mem_entry_o   = mem_q;
  assign bus.wb_entry_o    = wb_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic,
// checked against a queue-based pipeline model of the scoreboard rules.
module tb_hazard_scoreboard;
  import cpu_pkg::*;

  localparam int          TB_CNT_W = 3;
  localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  hazard_scoreboard_if #(.CNT_W(TB_CNT_W)) sb ();

  hazard_scoreboard #(.CNT_W(TB_CNT_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (sb.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  entry_t      m_pipe[$];   // [0]=EX, [1]=MEM, [2]=WB
  int unsigned m_cnt;

  function automatic void model_reset();
    m_pipe = '{entry_t'('0), entry_t'('0), entry_t'('0)};
    m_cnt  = 0;
  endfunction

  function automatic bit exp_stall();
    entry_t ex = m_pipe[0];
    bit reads_ex;
    bit hz;
    reads_ex = (sb.rs1_used_i && sb.rs1_i == ex.rd) || (sb.rs2_used_i && sb.rs2_i == ex.rd);
    hz = sb.id_valid_i && ex.v && ex.rw && ex.mr && ex.rd != 0 && reads_ex;
    return hz && !sb.flush_i && !sb.dmem_busy_i;
  endfunction

  function automatic bit exp_pc();
    return !exp_stall() && !sb.dmem_busy_i;
  endfunction

  function automatic bit exp_bubble();
    return (exp_stall() || sb.flush_i) && !sb.dmem_busy_i;
  endfunction

  function automatic bit exp_byp(input bit used, input logic [REG_AW-1:0] rs);
    entry_t wb = m_pipe[2];
    return used && wb.v && wb.rw && wb.rd != 0 && wb.rd == rs;
  endfunction

  function automatic void model_advance(input bit s);
    entry_t n;
    if (sb.dmem_busy_i) return;
    n = '0;
    if (!s && !sb.flush_i) begin
      n.v  = sb.id_valid_i;
      n.rd = sb.id_rd_i;
      n.rw = sb.id_regwrite_i;
      n.mr = sb.id_memread_i;
    end
    m_pipe.push_front(n);
    void'(m_pipe.pop_back());
    if (s && m_cnt < CNT_MAX) m_cnt++;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_id(input bit valid, input int rd, input bit rw, input bit mr,
                          input int rs1, input bit u1, input int rs2, input bit u2);
    sb.id_valid_i    = valid;
    sb.id_rd_i       = REG_AW'(rd);
    sb.id_regwrite_i = rw;
    sb.id_memread_i  = mr;
    sb.rs1_i         = REG_AW'(rs1);
    sb.rs1_used_i    = u1;
    sb.rs2_i         = REG_AW'(rs2);
    sb.rs2_used_i    = u2;
  endtask

  task automatic drive_ctl(input bit flush, input bit busy);
    sb.flush_i     = flush;
    sb.dmem_busy_i = busy;
  endtask

  task automatic clock_edge();
    bit s;
    s = exp_stall();
    @(posedge clk);
    model_advance(s);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    drive_ctl(0, 0);
    model_reset();
    @(negedge clk);
    n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", sb.stall_o); end
    n_cmp++; if (sb.stall_cnt_o !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", sb.stall_cnt_o); end
    n_cmp++; if (sb.pc_write_o !== 1'b1) begin n_bad++; $display("FAIL reset_pc_write got=%b exp=1", sb.pc_write_o); end
    n_cmp++; if ({sb.ex_entry_o, sb.mem_entry_o, sb.wb_entry_o} !== '0) begin n_bad++;
      $display("FAIL reset_entries got=%h exp=0", {sb.ex_entry_o, sb.mem_entry_o, sb.wb_entry_o}); end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use_rs1();
    drive_id(1, 5, 1, 1, 0, 0, 0, 0);           // lw x5
    clock_edge();
    drive_id(1, 6, 1, 0, 5, 1, 0, 0);           // add x6, x5, ...
    @(negedge clk);
    n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL lu_stall got=%b exp=1", sb.stall_o); end
    n_cmp++; if (sb.pc_write_o !== 1'b0 || sb.ifid_write_o !== 1'b0) begin n_bad++;
      $display("FAIL lu_write got=%b%b exp=00", sb.pc_write_o, sb.ifid_write_o); end
    n_cmp++; if (sb.idex_bubble_o !== 1'b1) begin n_bad++; $display("FAIL lu_bubble got=%b exp=1", sb.idex_bubble_o); end
    clock_edge();
    @(negedge clk);
    n_cmp++; if (sb.stall_o !== 1'b0 || sb.idex_bubble_o !== 1'b0 || sb.pc_write_o !== 1'b1) begin n_bad++;
      $display("FAIL lu_release got=%b%b%b exp=001", sb.stall_o, sb.idex_bubble_o, sb.pc_write_o); end
    n_cmp++; if (sb.stall_cnt_o !== TB_CNT_W'(1)) begin n_bad++; $display("FAIL lu_cnt got=%0d exp=1", sb.stall_cnt_o); end
    clock_edge();
  endtask

  task automatic test_no_false_stall();
    drive_id(1, 0, 1, 1, 0, 0, 0, 0);           // lw x0
    clock_edge();
    drive_id(1, 6, 1, 0, 0, 1, 0, 1);           // uses x0
    @(negedge clk);
    n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL x0_stall got=%b exp=0", sb.stall_o); end
    clock_edge();
    drive_id(1, 5, 1, 1, 0, 0, 0, 0);           // lw x5
    clock_edge();
    drive_id(1, 6, 1, 0, 1, 1, 5, 0);           // rs2=5 but unused
    @(negedge clk);
    n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL unused_rs2_stall got=%b exp=0", sb.stall_o); end
    clock_edge();
  endtask

  task automatic test_flush();
    drive_id(1, 5, 1, 1, 0, 0, 0, 0);
    clock_edge();
    drive_id(1, 6, 1, 0, 5, 1, 0, 0);
    drive_ctl(1, 0);
    @(negedge clk);
    n_cmp++; if (sb.stall_o !== 1'b0 || sb.idex_bubble_o !== 1'b1) begin n_bad++;
      $display("FAIL flush_ctl got=stall%b bub%b exp=stall0 bub1", sb.stall_o, sb.idex_bubble_o); end
    clock_edge();
    drive_ctl(0, 0);
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (sb.ex_entry_o.v !== 1'b0) begin n_bad++; $display("FAIL flush_ex_v got=%b exp=0", sb.ex_entry_o.v); end
    clock_edge();
  endtask

  task automatic test_freeze();
    entry_t      ex_snap;
    int unsigned cnt_snap;
    drive_id(1, 7, 1, 1, 0, 0, 0, 0);           // lw x7
    clock_edge();
    ex_snap  = sb.ex_entry_o;
    cnt_snap = m_cnt;
    drive_id(1, 8, 1, 0, 0, 0, 7, 1);
    drive_ctl(0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (sb.stall_o !== 1'b0 || sb.pc_write_o !== 1'b0) begin n_bad++;
        $display("FAIL freeze_ctl[%0d] got=stall%b pc%b exp=stall0 pc0", i, sb.stall_o, sb.pc_write_o); end
      n_cmp++; if (sb.ex_entry_o !== ex_snap || sb.stall_cnt_o !== TB_CNT_W'(cnt_snap)) begin n_bad++;
        $display("FAIL freeze_hold[%0d] got=ex%h cnt%0d exp=ex%h cnt%0d", i, sb.ex_entry_o, sb.stall_cnt_o, ex_snap, cnt_snap); end
      clock_edge();
    end
    drive_ctl(0, 0);
    @(negedge clk);
    n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL freeze_release_stall got=%b exp=1", sb.stall_o); end
    clock_edge();
    @(negedge clk);
    n_cmp++; if (sb.stall_cnt_o !== TB_CNT_W'(cnt_snap + 1) || sb.stall_o !== 1'b0) begin n_bad++;
      $display("FAIL freeze_after got=cnt%0d stall%b exp=cnt%0d stall0", sb.stall_cnt_o, sb.stall_o, cnt_snap + 1); end
    clock_edge();
  endtask

  task automatic test_bypass();
    for (int k = 0; k < 2; k++) begin
      drive_id(1, 9, (k == 0), 0, 0, 0, 0, 0);  // add x9 (then with rw=0)
      clock_edge();
      drive_id(0, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      clock_edge();
      drive_id(1, 3, 1, 0, 9, 1, 9, 1);
      @(negedge clk);
      n_cmp++; if ({sb.bypass_a_o, sb.bypass_b_o} !== ((k == 0) ? 2'b11 : 2'b00)) begin n_bad++;
        $display("FAIL bypass_rw%0d got=%b%b exp=%s", 1 - k, sb.bypass_a_o, sb.bypass_b_o, (k == 0) ? "11" : "00"); end
      clock_edge();
    end
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_id(1, 5, 1, 1, 0, 0, 0, 0);
      clock_edge();
      drive_id(1, 6, 1, 0, 5, 1, 0, 0);
      clock_edge();
    end
    @(negedge clk);
    n_cmp++; if (sb.stall_cnt_o !== TB_CNT_W'(7)) begin n_bad++; $display("FAIL sat_cnt got=%0d exp=7", sb.stall_cnt_o); end
    clock_edge();
    drive_id(1, 5, 1, 1, 0, 0, 0, 0);
    clock_edge();
    drive_id(1, 6, 1, 0, 5, 1, 0, 0);
    @(negedge clk);
    n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL midstall_pre got=%b exp=1", sb.stall_o); end
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (sb.stall_o !== 1'b0 || sb.stall_cnt_o !== '0) begin n_bad++;
      $display("FAIL midstall_rst got=stall%b cnt%0d exp=stall0 cnt0", sb.stall_o, sb.stall_cnt_o); end
    #1 rst = 1'b0;
    clock_edge();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
      drive_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
      @(negedge clk);
      n_cmp++;
      if (sb.stall_o !== exp_stall() || sb.pc_write_o !== exp_pc() || sb.ifid_write_o !== exp_pc() ||
          sb.idex_bubble_o !== exp_bubble()) begin
        n_bad++;
        $display("FAIL rnd_ctl[%0d] got=%b%b%b%b exp=%b%b%b%b", i, sb.stall_o, sb.pc_write_o, sb.ifid_write_o,
                 sb.idex_bubble_o, exp_stall(), exp_pc(), exp_pc(), exp_bubble());
      end
      n_cmp++;
      if (sb.bypass_a_o !== exp_byp(sb.rs1_used_i, sb.rs1_i) || sb.bypass_b_o !== exp_byp(sb.rs2_used_i, sb.rs2_i)) begin
        n_bad++;
        $display("FAIL rnd_bypass[%0d] got=%b%b exp=%b%b", i, sb.bypass_a_o, sb.bypass_b_o,
                 exp_byp(sb.rs1_used_i, sb.rs1_i), exp_byp(sb.rs2_used_i, sb.rs2_i));
      end
      n_cmp++;
      if (sb.stall_cnt_o !== TB_CNT_W'(m_cnt) || sb.ex_entry_o !== m_pipe[0] ||
          sb.mem_entry_o !== m_pipe[1] || sb.wb_entry_o !== m_pipe[2]) begin
        n_bad++;
        $display("FAIL rnd_state[%0d] got=cnt%0d %h/%h/%h exp=cnt%0d %h/%h/%h", i, sb.stall_cnt_o, sb.ex_entry_o,
                 sb.mem_entry_o, sb.wb_entry_o, m_cnt, m_pipe[0], m_pipe[1], m_pipe[2]);
      end
      clock_edge();
    end
    drive_ctl(0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load_use_rs1();
    test_no_false_stall();
    test_flush();
    test_freeze();
    test_bypass();
    test_saturation_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
